trace_capture_buffer: RTL
=========================

Name: trace_capture_buffer

Overview:
- Synthesisable on-chip retirement trace for the RV32I single-cycle core; replaces the simulation-only per-cycle $display trace.
- Sits beside the core and samples PC, instruction, ALU result and store data on each retiring instruction into a parametrised circular buffer.
- Arm/trigger/post-trigger FSM freezes a window around a trigger PC; software or a debug bench reads it back by index.

Parameters:
- DEPTH, 32, number of entries; power of 2, >= 4
- DATA_W, 32, width of pc/inst/alu/wdata fields
- POST_TRIG, 8, entries captured after the trigger entry; 0 .. DEPTH-1
- AW, $clog2(DEPTH), index width (derived; do not override)

Ports:
- i_clk  in  1  clock; all state updates on rising edge
- i_rst  in  1  asynchronous, active-high reset
- i_valid  in  1  an instruction retires this cycle
- i_pc  in  DATA_W  retiring PC
- i_inst  in  DATA_W  retiring instruction word
- i_alu  in  DATA_W  ALU result; store address for SW/SH/SB
- i_rs2_data  in  DATA_W  rs2 value; store data
- i_arm  in  1  arm/re-arm pulse
- i_trig_pc  in  DATA_W  trigger PC compare value
- i_trig_en  in  1  enable the trigger compare
- i_mode  in  2  capture filter: 00 all, 01 stores only (opcode 0100011), 10 control flow only (1100011/1101111/1100111), 11 all
- i_rd_addr  in  AW  read index; 0 = oldest valid entry
- o_rd_pc, o_rd_inst, o_rd_alu, o_rd_wdata  out  DATA_W each  read data, registered
- o_state  out  2  FSM state: 0 IDLE, 1 ARMED, 2 POST, 3 DONE
- o_count  out  AW+1  valid entries; saturates at DEPTH
- o_trig_idx  out  AW  read index (oldest-relative) of the trigger entry
- o_done  out  1  high in DONE

Behaviour:
- Reset: state IDLE, wr_ptr 0, count 0, post counter 0, all outputs 0. Entry storage need not be cleared.
- Entry: {pc, inst, alu, wdata}; wdata = i_rs2_data for opcode 0100011, else 0.
- Accept: i_valid && filter pass, in states ARMED or POST only.
  - Write at wr_ptr; wr_ptr increments mod DEPTH; count increments, saturating at DEPTH.
  - When full, the oldest entry is overwritten.
- Trigger: ARMED && i_valid && i_trig_en && i_pc == i_trig_pc.
  - The trigger entry is always written, bypassing the filter.
  - Its physical index is latched as trig_ptr.
- FSM transitions:
  - IDLE -> ARMED on i_arm; clears wr_ptr, count and post counter.
  - ARMED -> POST on trigger. If POST_TRIG == 0, ARMED -> DONE on the same edge instead.
  - POST: each accepted entry increments the post counter; -> DONE on the edge the POST_TRIG-th post entry is written.
  - DONE: no writes. i_arm -> ARMED with clear, same as from IDLE.
  - i_arm in ARMED or POST re-clears and stays/returns to ARMED.
- Trigger compare is evaluated only in ARMED. A trigger PC seen in IDLE, POST or DONE is ignored.
- Arm and trigger in the same cycle from IDLE: arm wins; nothing is captured that cycle.
- Readout:
  - phys = (wr_ptr - count + i_rd_addr) mod DEPTH; o_rd_* = mem[phys] one cycle after i_rd_addr is presented.
  - i_rd_addr >= count returns 0 on all o_rd_*.
  - Readout is valid in every state.
- o_trig_idx = (trig_ptr - (wr_ptr - count)) mod DEPTH; 0 unless a trigger has occurred since the last arm.
- Reset mid-operation: immediate return to the reset values above, asynchronously.

Optional Feature:
- TRACE_FILTER_EN
  - Defined: i_mode filtering active as described in Behaviour.
  - Undefined: every valid instruction passes the filter; i_mode is ignored; the port remains present.

Test Plan:
- Reset, no stimulus -> o_state=0, o_count=0, o_done=0, o_rd_* = 0.
- DEPTH=8, POST_TRIG=2, mode 00: arm, retire PCs 0x0,0x4,0x8, no trigger -> o_count=3; rd_addr=0 gives o_rd_pc=0x0 one cycle later; rd_addr=3 gives 0.
- Wrap: arm, retire PCs 0x00..0x2C (12 instrs), no trigger -> o_count=8; rd_addr=0 -> 0x10; rd_addr=7 -> 0x2C.
- Trigger: i_trig_pc=0x20, retire 0x00..0x2C -> state passes POST, then DONE after 0x28; last entry 0x28; 0x2C not stored; o_trig_idx=5 (entries 0x0C..0x28).
- TRACE_FILTER_EN, mode 01: retire addi 0x00500093 then sw 0x00112023 with i_alu=0x100, i_rs2_data=0xDEAD -> o_count=1; entry alu=0x100, wdata=0xDEAD.
- Assert i_rst during POST -> same cycle o_state=0, o_count=0, o_trig_idx=0; a following arm captures from index 0.

Source files
------------

// File: rtl/trace_capture_buffer_if.sv
// trace_capture_buffer_if
//   Bundles the retirement-sample inputs, arm/trigger controls, readout index
//   and all status/readout outputs of trace_capture_buffer.
//   Clock and reset are kept as plain ports on the module.
//   master : drives the core samples and controls and receives readout/status
//   slave  : the capture buffer itself
//   Ports carried:
//     i_valid, i_pc, i_inst, i_alu, i_rs2_data  retirement sample
//     i_arm, i_trig_pc, i_trig_en, i_mode       capture control
//     i_rd_addr                                 readout index (0 = oldest)
//     o_rd_pc, o_rd_inst, o_rd_alu, o_rd_wdata  registered readout data
//     o_state, o_count, o_trig_idx, o_done      status
interface trace_capture_buffer_if #(
   parameter int DATA_W = 32,
   parameter int AW     = 5
);
   logic              i_valid;
   logic [DATA_W-1:0] i_pc;
   logic [DATA_W-1:0] i_inst;
   logic [DATA_W-1:0] i_alu;
   logic [DATA_W-1:0] i_rs2_data;
   logic              i_arm;
   logic [DATA_W-1:0] i_trig_pc;
   logic              i_trig_en;
   logic [1:0]        i_mode;
   logic [AW-1:0]     i_rd_addr;
   logic [DATA_W-1:0] o_rd_pc;
   logic [DATA_W-1:0] o_rd_inst;
   logic [DATA_W-1:0] o_rd_alu;
   logic [DATA_W-1:0] o_rd_wdata;
   logic [1:0]        o_state;
   logic [AW:0]       o_count;
   logic [AW-1:0]     o_trig_idx;
   logic              o_done;

   modport master (
      output i_valid, i_pc, i_inst, i_alu, i_rs2_data,
      output i_arm, i_trig_pc, i_trig_en, i_mode, i_rd_addr,
      input  o_rd_pc, o_rd_inst, o_rd_alu, o_rd_wdata,
      input  o_state, o_count, o_trig_idx, o_done
   );

   modport slave (
      input  i_valid, i_pc, i_inst, i_alu, i_rs2_data,
      input  i_arm, i_trig_pc, i_trig_en, i_mode, i_rd_addr,
      output o_rd_pc, o_rd_inst, o_rd_alu, o_rd_wdata,
      output o_state, o_count, o_trig_idx, o_done
   );
endinterface

// File: rtl/trace_capture_buffer.sv
// trace_capture_buffer
//   On-chip retirement trace for the RV32I single-cycle core. Each retiring
//   instruction that passes the capture filter is written as
//   {pc, inst, alu, wdata} into a DEPTH-entry circular buffer. An
//   arm/trigger/post-trigger FSM freezes a window around a trigger PC;
//   entries are read back by oldest-relative index with one cycle latency.
//   Ports:
//     i_clk  clock (rising edge)
//     i_rst  asynchronous active-high reset
//     bus    trace_capture_buffer_if.slave (samples, controls, readout, status)
//   Optional feature macro: TRACE_FILTER_EN
//     defined   -> i_mode selects all / stores only / control flow only
//     undefined -> every valid instruction is captured, i_mode ignored
module trace_capture_buffer #(
   parameter int DEPTH     = 32,
   parameter int DATA_W    = 32,
   parameter int POST_TRIG = 8,
   parameter int AW        = $clog2(DEPTH)
) (
   input logic                   i_clk,
   input logic                   i_rst,
   trace_capture_buffer_if.slave bus
);
   localparam int             CW        = AW + 1;
   localparam logic [CW-1:0]  FULL      = CW'(DEPTH);
   localparam logic [CW-1:0]  POST_LAST = CW'(POST_TRIG);
   localparam logic [6:0]     OP_STORE  = 7'b0100011;
   localparam logic [6:0]     OP_BRANCH = 7'b1100011;
   localparam logic [6:0]     OP_JAL    = 7'b1101111;
   localparam logic [6:0]     OP_JALR   = 7'b1100111;

   typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, POST = 2'd2, DONE = 2'd3} state_t;

   state_t              state, state_nxt;
   logic [4*DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]       wr_ptr, trig_ptr, base, phys;
   logic [CW-1:0]       count, post_cnt;
   logic                trig_seen;
   logic [6:0]          opcode;
   logic                filter_pass, trigger, capture;
   logic [DATA_W-1:0]   wdata;
   logic [DATA_W-1:0]   rd_pc_p1, rd_inst_p1, rd_alu_p1, rd_wdata_p1;

`ifdef TRACE_FILTER_EN
   function automatic logic filter_ok(input logic [1:0] mode, input logic [6:0] op);
      case (mode)
         2'b01:   filter_ok = (op == OP_STORE);
         2'b10:   filter_ok = (op == OP_BRANCH) || (op == OP_JAL) || (op == OP_JALR);
         default: filter_ok = 1'b1;
      endcase
   endfunction

   assign filter_pass = filter_ok(bus.i_mode, opcode);
`else
   // Mode input stays on the interface but has no effect in this build.
   logic unused_mode;
   assign unused_mode = ^bus.i_mode;
   assign filter_pass = 1'b1;
`endif

   assign opcode = bus.i_inst[6:0];
   assign wdata  = (opcode == OP_STORE) ? bus.i_rs2_data : '0;

   // A trigger entry is written even if the filter would reject it. Arm takes
   // priority over everything in the same cycle, so nothing is captured then.
   assign trigger = (state == ARMED) && bus.i_valid && bus.i_trig_en &&
                    (bus.i_pc == bus.i_trig_pc);
   assign capture = !bus.i_arm && ((state == ARMED) || (state == POST)) &&
                    bus.i_valid && (filter_pass || trigger);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (bus.i_arm) begin
         state_nxt = ARMED;
      end else begin
         case (state)
            ARMED:   if (trigger) state_nxt = (POST_TRIG == 0) ? DONE : POST;
            POST:    if (capture && (post_cnt + CW'(1) == POST_LAST)) state_nxt = DONE;
            default: state_nxt = state;
         endcase
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wr_ptr    <= '0;
         count     <= '0;
         post_cnt  <= '0;
         trig_ptr  <= '0;
         trig_seen <= 1'b0;
      end else if (bus.i_arm) begin
         wr_ptr    <= '0;
         count     <= '0;
         post_cnt  <= '0;
         trig_ptr  <= '0;
         trig_seen <= 1'b0;
      end else if (capture) begin
         wr_ptr <= wr_ptr + AW'(1);
         if (count != FULL) count <= count + CW'(1);
         if (trigger) begin
            trig_ptr  <= wr_ptr;
            trig_seen <= 1'b1;
         end
         if (state == POST) post_cnt <= post_cnt + CW'(1);
      end
   end

   // Entry storage carries no reset.
   always_ff @(posedge i_clk) begin
      if (capture) mem[wr_ptr] <= {bus.i_pc, bus.i_inst, bus.i_alu, wdata};
   end

   // When full, count[AW-1:0] wraps to 0 so the oldest entry is at wr_ptr.
   assign base = wr_ptr - count[AW-1:0];
   assign phys = base + bus.i_rd_addr;

   // Readout stage p1
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         {rd_pc_p1, rd_inst_p1, rd_alu_p1, rd_wdata_p1} <= '0;
      end else if ({1'b0, bus.i_rd_addr} < count) begin
         {rd_pc_p1, rd_inst_p1, rd_alu_p1, rd_wdata_p1} <= mem[phys];
      end else begin
         {rd_pc_p1, rd_inst_p1, rd_alu_p1, rd_wdata_p1} <= '0;
      end
   end

   assign bus.o_rd_pc    = rd_pc_p1;
   assign bus.o_rd_inst  = rd_inst_p1;
   assign bus.o_rd_alu   = rd_alu_p1;
   assign bus.o_rd_wdata = rd_wdata_p1;
   assign bus.o_state    = state;
   assign bus.o_count    = count;
   assign bus.o_done     = (state == DONE);
   assign bus.o_trig_idx = trig_seen ? (trig_ptr - base) : '0;
endmodule
